fmult_accum: RTL and testbench



---
 rtl/fmult_accum.sv | 255 +++++++++++++++++++++++++
 tb/tb_fmult_accum.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmult_accum.sv
// fmult_accum: sequential G.726 predictor engine.
//
// Streams NUM_TAPS (coefficient, float signal) pairs through a two-stage
// FMULT pipeline and sums the products modulo 2^16. Taps 0..ZERO_TAPS-1
// form the zero-section estimate SEZ. All taps together form the full
// signal estimate SE.
//
// Ports:
//   CLK      clock, rising edge
//   RESET_N  synchronous active-low reset
//   I_START  one-cycle pulse, begins an estimate (honoured only when idle)
//   I_VALID  a tap is present on I16_TC / I11_FL
//   O_READY  a tap is accepted this cycle when I_VALID is also high
//   I16_TC   coefficient An/Bn, two's complement
//   I11_FL   signal {S, EXP[3:0], MANT[5:0]}
//   O16_WA   last product from stage 1
//   O15_SEZ  SEZI[15:1]
//   O15_SE   SEI[15:1]
//   O_DONE   one-cycle pulse; O15_SEZ and O15_SE are valid
//   O_BUSY   high from START acceptance until DONE
//   O_OVF    sticky signed-overflow flag of the accumulator
//
// Optional feature: define FMULT_ACCUM_OVF_EN to build the overflow flag.
// Without it O_OVF is tied low. The sum always wraps modulo 2^16.

module fmult_accum #(
    parameter int NUM_TAPS  = 8,
    parameter int ZERO_TAPS = 6
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        I_START,
    input  logic        I_VALID,
    output logic        O_READY,
    input  logic [15:0] I16_TC,
    input  logic [10:0] I11_FL,
    output logic [15:0] O16_WA,
    output logic [14:0] O15_SEZ,
    output logic [14:0] O15_SE,
    output logic        O_DONE,
    output logic        O_BUSY,
    output logic        O_OVF
);

    localparam int CW = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam logic [CW-1:0] LAST_TAP  = CW'(NUM_TAPS - 1);
    localparam logic [CW-1:0] ZERO_LAST = CW'(ZERO_TAPS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic          ready;
    logic          accept;
    logic          start_go;
    logic          drain_done;

    logic [CW-1:0] cnt;

    // Input register (accept edge).
    logic          p0_valid;
    logic [CW-1:0] p0_idx;
    logic [15:0]   tap_tc;
    logic [10:0]   tap_fl;

    // Stage 1 register (accept edge + 1).
    logic          p1_valid;
    logic [CW-1:0] p1_idx;
    logic [15:0]   wa_reg;

    // Stage 2 accumulator (accept edge + 2).
    logic [15:0]   acc;
    logic [15:0]   sum;
    logic [14:0]   sezi;

    // FMULT combinational signals.
    logic [15:0]   sh_val;
    logic          an_s;
    logic [12:0]   an_mag;
    logic [3:0]    an_exp;
    logic [5:0]    an_mant;
    logic          w_s;
    logic [4:0]    w_exp;
    logic [7:0]    w_mant;
    logic [14:0]   w_base;
    logic [14:0]   w_mag;
    logic [15:0]   wa;

    //--------------------------------------------------------------------
    // FSM
    //--------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        O_BUSY     = 1'b0;
        O_DONE     = 1'b0;
        start_go   = 1'b0;
        drain_done = 1'b0;
        case (state)
            S_IDLE: begin
                if (I_START) begin
                    start_go   = 1'b1;
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                ready  = 1'b1;
                O_BUSY = 1'b1;
                if (I_VALID && (cnt == LAST_TAP)) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                O_BUSY = 1'b1;
                // Both pipeline stages empty means the final add has landed.
                if (!p0_valid && !p1_valid) begin
                    drain_done = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                O_DONE     = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign O_READY = ready;
    assign accept  = ready && I_VALID;

    //--------------------------------------------------------------------
    // FMULT stage 1 (combinational on the input register)
    //--------------------------------------------------------------------
    always_comb begin
        an_s   = tap_tc[15];
        sh_val = 16'($signed(tap_tc) >>> 2);
        an_mag = an_s ? 13'(16'd0 - sh_val) : 13'(sh_val);

        an_exp = 4'd0;
        for (int unsigned i = 0; i < 13; i++) begin
            if (an_mag[i]) begin
                an_exp = 4'(i + 1);
            end
        end

        if (an_mag == 13'd0) begin
            an_mant = 6'd32;
        end else begin
            an_mant = 6'({an_mag, 6'b000000} >> an_exp);
        end

        w_s    = an_s ^ tap_fl[10];
        w_exp  = {1'b0, an_exp} + {1'b0, tap_fl[9:6]};
        w_mant = 8'((({6'b000000, an_mant} * {6'b000000, tap_fl[5:0]}) + 12'd48) >> 4);
        w_base = {w_mant, 7'b0000000};

        // Truncation to 15 bits implements the &32767 mask.
        if (w_exp > 5'd26) begin
            w_mag = w_base << (w_exp - 5'd26);
        end else begin
            w_mag = w_base >> (5'd26 - w_exp);
        end

        wa = w_s ? (16'd0 - {1'b0, w_mag}) : {1'b0, w_mag};
    end

    assign sum = acc + wa_reg;

    //--------------------------------------------------------------------
    // Datapath
    //--------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            cnt      <= '0;
            p0_valid <= 1'b0;
            p0_idx   <= '0;
            tap_tc   <= '0;
            tap_fl   <= '0;
            p1_valid <= 1'b0;
            p1_idx   <= '0;
            wa_reg   <= '0;
            acc      <= '0;
            sezi     <= '0;
            O15_SEZ  <= '0;
            O15_SE   <= '0;
        end else begin
            p0_valid <= accept;
            if (accept) begin
                tap_tc <= I16_TC;
                tap_fl <= I11_FL;
                p0_idx <= cnt;
                cnt    <= cnt + 1'b1;
            end

            p1_valid <= p0_valid;
            if (p0_valid) begin
                wa_reg <= wa;
                p1_idx <= p0_idx;
            end

            if (start_go) begin
                acc  <= '0;
                cnt  <= '0;
                sezi <= '0;
            end else if (p1_valid) begin
                acc <= sum;
                if (p1_idx == ZERO_LAST) begin
                    sezi <= sum[15:1];
                end
            end

            if (drain_done) begin
                O15_SEZ <= sezi;
                O15_SE  <= acc[15:1];
            end
        end
    end

    assign O16_WA = wa_reg;

`ifdef FMULT_ACCUM_OVF_EN
    logic ovf;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            ovf <= 1'b0;
        end else if (start_go) begin
            ovf <= 1'b0;
        end else if (p1_valid && (acc[15] == wa_reg[15]) && (sum[15] != acc[15])) begin
            ovf <= 1'b1;
        end
    end

    assign O_OVF = ovf;
`else
    assign O_OVF = 1'b0;
`endif

endmodule

// File: tb/tb_fmult_accum.sv
// Testbench for fmult_accum: table of estimate vectors with hand-derived
// expected results, driven into the DUT. A scoreboard queue holds the
// expected results and is checked whenever O_DONE pulses. Separate
// sequences cover reset mid-load, taps presented while idle, and runs
// with I_VALID gaps and stray START pulses.

module tb_fmult_accum;

    logic        CLK;
    logic        RESET_N;
    logic        I_START;
    logic        I_VALID;
    logic        O_READY;
    logic [15:0] I16_TC;
    logic [10:0] I11_FL;
    logic [15:0] O16_WA;
    logic [14:0] O15_SEZ;
    logic [14:0] O15_SE;
    logic        O_DONE;
    logic        O_BUSY;
    logic        O_OVF;

    fmult_accum #(
        .NUM_TAPS (8),
        .ZERO_TAPS(6)
    ) dut (
        .CLK    (CLK),
        .RESET_N(RESET_N),
        .I_START(I_START),
        .I_VALID(I_VALID),
        .O_READY(O_READY),
        .I16_TC (I16_TC),
        .I11_FL (I11_FL),
        .O16_WA (O16_WA),
        .O15_SEZ(O15_SEZ),
        .O15_SE (O15_SE),
        .O_DONE (O_DONE),
        .O_BUSY (O_BUSY),
        .O_OVF  (O_OVF)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic [7:0][15:0] tc;
        logic [7:0][10:0] fl;
        logic [15:0]      wa0;
        logic [15:0]      wa_last;
        logic [14:0]      sez;
        logic [14:0]      se;
        logic             ovf;
    } vec_t;

    typedef struct {
        logic [15:0] wa_last;
        logic [14:0] sez;
        logic [14:0] se;
        logic        ovf;
        int          lat;
        int          start_cyc;
    } exp_t;

    vec_t vecs[7];
    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic logic ovf_exp(input logic v);
`ifdef FMULT_ACCUM_OVF_EN
        return v;
`else
        return v & 1'b0;
`endif
    endfunction

    // Scoreboard consumer.
    always @(negedge CLK) begin
        if (RESET_N === 1'b1 && O_DONE === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                mon_e = sb.pop_front();
                chk("sez", 32'(O15_SEZ), 32'(mon_e.sez));
                chk("se", 32'(O15_SE), 32'(mon_e.se));
                chk("wa_last", 32'(O16_WA), 32'(mon_e.wa_last));
                chk("ovf", 32'(O_OVF), 32'(mon_e.ovf));
                chk("busy_at_done", 32'(O_BUSY), 32'd0);
                if (mon_e.lat != 0) begin
                    chk("latency", 32'(cyc - mon_e.start_cyc), 32'(mon_e.lat));
                end
            end
        end
    end

    task automatic wait_done();
        for (int k = 0; k < 40 && sb.size() != 0; k++) @(posedge CLK);
        #1;
        chk("done_seen", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic run_vec(input int v, input bit gaps);
        exp_t e;
        int   n;
        @(posedge CLK);
        #1;
        I_START     = 1'b1;
        e.sez       = vecs[v].sez;
        e.se        = vecs[v].se;
        e.wa_last   = vecs[v].wa_last;
        e.ovf       = ovf_exp(vecs[v].ovf);
        e.lat       = gaps ? 0 : 12;
        e.start_cyc = cyc;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        I_START = 1'b0;
        for (int t = 0; t < 8; t++) begin
            if (gaps) begin
                n = $urandom_range(0, 2);
                repeat (n) begin
                    I_VALID = 1'b0;
                    I16_TC  = 16'($urandom);
                    I_START = 1'($urandom_range(0, 1));
                    @(posedge CLK);
                    #1;
                    chk("gap_busy", 32'(O_BUSY), 32'd1);
                end
            end
            I_VALID = 1'b1;
            I16_TC  = vecs[v].tc[t];
            I11_FL  = vecs[v].fl[t];
            @(posedge CLK);
            #1;
            if (!gaps && t == 1) chk("wa_tap0", 32'(O16_WA), 32'(vecs[v].wa0));
        end
        I_VALID = 1'b0;
        I_START = 1'b0;
        if (gaps) begin
            // Extra tap after the last one must be refused.
            I_VALID = 1'b1;
            I16_TC  = 16'h7FFF;
            I11_FL  = 11'h3FF;
            chk("drain_ready", 32'(O_READY), 32'd0);
            @(posedge CLK);
            #1;
            I_VALID = 1'b0;
        end
        wait_done();
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_ready"}, 32'(O_READY), 32'd0);
        chk({tag, "_busy"}, 32'(O_BUSY), 32'd0);
        chk({tag, "_done"}, 32'(O_DONE), 32'd0);
        chk({tag, "_wa"}, 32'(O16_WA), 32'd0);
        chk({tag, "_sez"}, 32'(O15_SEZ), 32'd0);
        chk({tag, "_se"}, 32'(O15_SE), 32'd0);
        chk({tag, "_ovf"}, 32'(O_OVF), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Vector table: unused taps are TC=0, FL={0,0,32}, product 0.
        for (int v = 0; v < 7; v++) begin
            for (int t = 0; t < 8; t++) begin
                vecs[v].tc[t] = 16'h0000;
                vecs[v].fl[t] = 11'h020;
            end
            vecs[v].wa0     = 16'h0000;
            vecs[v].wa_last = 16'h0000;
            vecs[v].sez     = 15'h0000;
            vecs[v].se      = 15'h0000;
            vecs[v].ovf     = 1'b0;
        end
        // 1: tap0 +16384 x {0,14,32}: WA 0x4300
        vecs[1].tc[0] = 16'h4000; vecs[1].fl[0] = 11'h3A0;
        vecs[1].wa0 = 16'h4300; vecs[1].sez = 15'h2180; vecs[1].se = 15'h2180;
        // 2: tap0 -16384: WA 0xBD00
        vecs[2].tc[0] = 16'hC000; vecs[2].fl[0] = 11'h3A0;
        vecs[2].wa0 = 16'hBD00; vecs[2].sez = 15'h5E80; vecs[2].se = 15'h5E80;
        // 3: taps 0 and 6: SEI 0x8600, signed overflow
        vecs[3].tc[0] = 16'h4000; vecs[3].fl[0] = 11'h3A0;
        vecs[3].tc[6] = 16'h4000; vecs[3].fl[6] = 11'h3A0;
        vecs[3].wa0 = 16'h4300; vecs[3].sez = 15'h2180; vecs[3].se = 15'h4300;
        vecs[3].ovf = 1'b1;
        // 4: tap7 only: pole section only
        vecs[4].tc[7] = 16'h4000; vecs[4].fl[7] = 11'h3A0;
        vecs[4].wa_last = 16'h4300; vecs[4].se = 15'h2180;
        // 5: mixed signs, right shifts: -792, +186, -16
        vecs[5].tc[1] = 16'h2000; vecs[5].fl[1] = 11'h6B0;
        vecs[5].tc[6] = 16'h1234; vecs[5].fl[6] = 11'h268;
        vecs[5].tc[7] = 16'hFFFF; vecs[5].fl[7] = 11'h3FF;
        vecs[5].wa_last = 16'hFFF0; vecs[5].sez = 15'h7E74; vecs[5].se = 15'h7EC9;
        // 6: max magnitudes, WEXP=28 with mask: 0x7600 twice
        vecs[6].tc[0] = 16'h7FFF; vecs[6].fl[0] = 11'h3FF;
        vecs[6].tc[7] = 16'h7FFF; vecs[6].fl[7] = 11'h3FF;
        vecs[6].wa0 = 16'h7600; vecs[6].wa_last = 16'h7600;
        vecs[6].sez = 15'h3B00; vecs[6].se = 15'h7600; vecs[6].ovf = 1'b1;

        RESET_N = 1'b0;
        I_START = 1'b0;
        I_VALID = 1'b0;
        I16_TC  = 16'h0000;
        I11_FL  = 11'h000;
        repeat (3) @(posedge CLK);
        #1;
        check_zero_outputs("reset");
        RESET_N = 1'b1;

        for (int v = 0; v < 7; v++) run_vec(v, 1'b0);

        // Reset after three accepted taps: abort, no DONE, outputs cleared.
        @(posedge CLK);
        #1;
        I_START = 1'b1;
        @(posedge CLK);
        #1;
        I_START = 1'b0;
        for (int t = 0; t < 3; t++) begin
            I_VALID = 1'b1;
            I16_TC  = 16'h7FFF;
            I11_FL  = 11'h3FF;
            @(posedge CLK);
            #1;
        end
        I_VALID = 1'b0;
        chk("abort_wa", 32'(O16_WA), 32'h7600);
        RESET_N = 1'b0;
        @(posedge CLK);
        #1;
        check_zero_outputs("midreset");
        RESET_N = 1'b1;
        repeat (16) @(posedge CLK);
        run_vec(1, 1'b0);

        // Taps presented while idle are ignored.
        @(posedge CLK);
        #1;
        I_VALID = 1'b1;
        I16_TC  = 16'h7FFF;
        I11_FL  = 11'h3FF;
        repeat (3) @(posedge CLK);
        #1;
        chk("idle_ready", 32'(O_READY), 32'd0);
        chk("idle_busy", 32'(O_BUSY), 32'd0);
        I_VALID = 1'b0;
        run_vec(0, 1'b0);

        // Gapped runs with stray START pulses must match the gapless results.
        run_vec(5, 1'b1);
        run_vec(3, 1'b1);
        run_vec(6, 1'b1);

        repeat (4) @(posedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
